// File: rtl/perf_monitor_multi_if.sv
// Bus bundle for the performance monitor: event strobes, config write port,
// read port, interrupt and FSM state.
interface perf_monitor_multi_if #(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 32,
  parameter int ADDR_W  = 4
);
  logic [NUM_EVT-1:0] evt_i;
  logic               cfg_we;
  logic [ADDR_W-1:0]  cfg_addr;
  logic [CNT_W-1:0]   cfg_wdata;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic [CNT_W-1:0]   rd_data;
  logic               rd_valid;
  logic               ovf_irq;
  logic [1:0]         state_o;

  // Read handshake: rd_en is sampled on a clock edge and answered one cycle
  // later with rd_valid=1 and rd_data; there is no backpressure.
  // rd_valid drops when rd_en is low, while rd_data keeps its last value.
  modport master (
    output evt_i, cfg_we, cfg_addr, cfg_wdata, rd_en, rd_addr,
    input  rd_data, rd_valid, ovf_irq, state_o
  );

  modport slave (
    input  evt_i, cfg_we, cfg_addr, cfg_wdata, rd_en, rd_addr,
    output rd_data, rd_valid, ovf_irq, state_o
  );
endinterface

// File: rtl/perf_monitor_multi.sv
// Performance monitor: free-running cycle counter plus NUM_EVT event counters
// with wrap/saturate, per-counter overflow flags, irq and freeze-on-overflow.
module perf_monitor_multi #(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 32,
  parameter int ADDR_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  perf_monitor_multi_if.slave  bus
);

  // Index 0 is the cycle counter, index i+1 is event counter i; STATUS uses
  // the same bit order.
  localparam int NCNT = NUM_EVT + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FROZEN = 2'd2
  } state_t;

  state_t           r_state;
  logic [2:0]       r_ctrl;
  logic [NCNT-1:0]  r_status;
  logic [CNT_W-1:0] r_cnt [NCNT];
  logic [CNT_W-1:0] r_rd_data;
  logic             r_rd_valid;
  logic             r_irq;

  logic             w_run;
  logic             w_ctrl_wr;
  logic             w_status_wr;
  logic [2:0]       w_ctrl_nxt;
  logic [NCNT-1:0]  w_w1c_mask;
  logic [NCNT-1:0]  w_cnt_inc;
  logic [NCNT-1:0]  w_cnt_wr;
  logic [NCNT-1:0]  w_ovf;
  logic [NCNT-1:0]  w_status_nxt;
  logic [CNT_W-1:0] w_cnt_nxt [NCNT];
  logic [CNT_W-1:0] w_rd_mux;

  always_comb begin
    w_run       = (r_state == S_RUN);
    w_ctrl_wr   = bus.cfg_we && (bus.cfg_addr == ADDR_W'(0));
    w_status_wr = bus.cfg_we && (bus.cfg_addr == ADDR_W'(1));
    w_ctrl_nxt  = w_ctrl_wr ? bus.cfg_wdata[2:0] : r_ctrl;
    w_w1c_mask  = w_status_wr ? NCNT'(bus.cfg_wdata) : '0;
    w_cnt_inc   = w_run ? {bus.evt_i, 1'b1} : '0;
    w_cnt_wr    = '0;
    w_ovf       = '0;
    for (int k = 0; k < NCNT; k++) begin
      w_cnt_wr[k]  = bus.cfg_we && (bus.cfg_addr == ADDR_W'(k + 2));
      w_cnt_nxt[k] = r_cnt[k];
      // A config write to a counter swallows that cycle's increment.
      if (w_cnt_wr[k]) begin
        w_cnt_nxt[k] = bus.cfg_wdata;
      end else if (w_cnt_inc[k]) begin
        if (&r_cnt[k]) begin
          w_ovf[k]     = 1'b1;
          w_cnt_nxt[k] = r_ctrl[2] ? r_cnt[k] : '0;
        end else begin
          w_cnt_nxt[k] = r_cnt[k] + CNT_W'(1);
        end
      end
    end
    // New overflow beats a same-cycle write-1-to-clear.
    w_status_nxt = (r_status & ~w_w1c_mask) | w_ovf;
  end

  always_comb begin
    w_rd_mux = '0;
    if (bus.rd_addr == ADDR_W'(0)) begin
      w_rd_mux = CNT_W'(r_ctrl);
    end else if (bus.rd_addr == ADDR_W'(1)) begin
      w_rd_mux = CNT_W'(r_status);
    end else begin
      for (int k = 0; k < NCNT; k++) begin
        if (bus.rd_addr == ADDR_W'(k + 2)) begin
          w_rd_mux = r_cnt[k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ctrl   <= '0;
      r_status <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_ctrl   <= w_ctrl_nxt;
      r_status <= w_status_nxt;
      r_irq    <= |r_status;
      case (r_state)
        S_IDLE: begin
          if (w_ctrl_wr && w_ctrl_nxt[0]) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // A CTRL write overrides any freeze request in the same cycle.
          if (w_ctrl_wr) begin
            r_state <= w_ctrl_nxt[0] ? S_RUN : S_IDLE;
          end else if ((|w_ovf) && r_ctrl[1]) begin
            r_state <= S_FROZEN;
          end
        end
        S_FROZEN: begin
          if (w_ctrl_wr && !w_ctrl_nxt[0]) begin
            r_state <= S_IDLE;
          end else if ((w_status_nxt == '0) && w_ctrl_nxt[0]) begin
            r_state <= S_RUN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCNT; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCNT; k++) begin
        r_cnt[k] <= w_cnt_nxt[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        r_rd_data <= w_rd_mux;
      end
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.ovf_irq  = r_irq;
  assign bus.state_o  = r_state;

endmodule

// File: tb/tb_perf_monitor_multi.sv
// Self-checking bench for perf_monitor_multi with 8-bit counters so that
// wrap and saturation are reachable in a few cycles.
module tb_perf_monitor_multi;

  localparam int NUM_EVT = 4;
  localparam int CNT_W   = 8;
  localparam int ADDR_W  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  perf_monitor_multi_if #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus ();

  perf_monitor_multi #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [CNT_W-1:0] exp_q[$];
  string            tag_q[$];
  logic [CNT_W-1:0] mon_exp;
  string            mon_tag;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    step();
  endtask

  task automatic cfg_write(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    step();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic issue_read(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] e, input string tag);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] e, input string tag);
    issue_read(a, e, tag);
    step();
    bus.rd_en = 1'b0;
    check_eq({tag, "_valid"}, bus.rd_valid, 1);
  endtask

  // Read-data scoreboard: every rd_valid must match the oldest queued read.
  always @(posedge clk) begin
    #2;
    if (bus.rd_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("rd_unexpected", bus.rd_valid, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        check_eq(mon_tag, bus.rd_data, mon_exp);
      end
    end
  end

  initial begin
    bus.evt_i     = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;

    #12;
    check_eq("rst_state", bus.state_o, 0);
    check_eq("rst_irq", bus.ovf_irq, 0);
    check_eq("rst_rd_valid", bus.rd_valid, 0);
    check_eq("rst_rd_data", bus.rd_data, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Basic counting over ten RUN cycles.
    bus.evt_i = 4'b0101;
    cfg_write(0, 8'd1);
    check_eq("t1_state_run", bus.state_o, 1);
    repeat (9) step();
    cfg_write(0, 8'd0);
    bus.evt_i = '0;
    check_eq("t1_state_idle", bus.state_o, 0);
    do_read(2, 8'd10, "t1_cycle");
    do_read(3, 8'd10, "t1_evt0");
    do_read(4, 8'd0,  "t1_evt1");
    do_read(5, 8'd10, "t1_evt2");
    do_read(6, 8'd0,  "t1_evt3");

    // Wrap mode.
    pulse_reset();
    cfg_write(4, 8'hFE);
    bus.evt_i = 4'b0010;
    cfg_write(0, 8'd1);
    step();
    do_read(4, 8'hFF, "t2_evt1_ff");
    do_read(4, 8'h00, "t2_evt1_wrap");
    check_eq("t2_irq", bus.ovf_irq, 1);
    bus.evt_i = '0;
    do_read(4, 8'h01, "t2_evt1_01");
    cfg_write(0, 8'd0);
    do_read(1, 8'h04, "t2_status");

    // Saturate with freeze-on-overflow, then resume by clearing STATUS.
    pulse_reset();
    cfg_write(4, 8'hFE);
    bus.evt_i = 4'b0010;
    cfg_write(0, 8'd7);
    step();
    step();
    check_eq("t3_state_frozen", bus.state_o, 2);
    repeat (3) step();
    bus.evt_i = '0;
    do_read(2, 8'd2,  "t3_cycle_frozen");
    do_read(4, 8'hFF, "t3_evt1_sat");
    do_read(1, 8'h04, "t3_status");
    cfg_write(1, 8'h04);
    check_eq("t3_state_resume", bus.state_o, 1);
    do_read(2, 8'd2, "t3_resume0");
    do_read(2, 8'd3, "t3_resume1");
    check_eq("t3_irq_clear", bus.ovf_irq, 0);
    cfg_write(0, 8'd0);

    // Same-cycle collisions.
    pulse_reset();
    cfg_write(0, 8'd1);
    bus.evt_i = 4'b0001;
    cfg_write(3, 8'd5);
    bus.evt_i = '0;
    cfg_write(0, 8'd0);
    do_read(3, 8'd5, "t4_write_wins");
    cfg_write(3, 8'hFF);
    cfg_write(0, 8'd1);
    bus.evt_i = 4'b0001;
    step();
    bus.evt_i = '0;
    cfg_write(3, 8'hFF);
    bus.evt_i = 4'b0001;
    cfg_write(1, 8'h02);
    bus.evt_i = '0;
    cfg_write(0, 8'd0);
    do_read(1, 8'h02, "t4_set_wins");
    cfg_write(1, 8'h02);
    do_read(1, 8'h00, "t4_w1c");

    // Read timing, hold, unmapped addresses, read-during-write.
    pulse_reset();
    cfg_write(2, 8'h40);
    cfg_write(0, 8'd1);
    do_read(2, 8'h40, "t5_cycle_t");
    do_read(2, 8'h41, "t5_cycle_t1");
    step();
    check_eq("t5_valid_drop", bus.rd_valid, 0);
    check_eq("t5_data_hold", bus.rd_data, 8'h41);
    do_read(15, 8'h00, "t5_unmapped");
    cfg_write(0, 8'd0);
    cfg_write(15, 8'hAA);
    do_read(15, 8'h00, "t5_unmapped_wr");
    issue_read(3, 8'h00, "t5_rd_old");
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 3;
    bus.cfg_wdata = 8'h33;
    step();
    bus.cfg_we = 1'b0;
    bus.rd_en  = 1'b0;
    do_read(3, 8'h33, "t5_rd_new");
    do_read(0, 8'h00, "t5_ctrl");

    // Asynchronous reset between edges while running.
    pulse_reset();
    cfg_write(3, 8'hFF);
    bus.evt_i = 4'b1111;
    cfg_write(0, 8'd1);
    repeat (3) step();
    check_eq("t6_irq_pre", bus.ovf_irq, 1);
    check_eq("t6_state_pre", bus.state_o, 1);
    #3;
    rst = 1'b1;
    #1;
    check_eq("t6_state_async", bus.state_o, 0);
    check_eq("t6_irq_async", bus.ovf_irq, 0);
    check_eq("t6_rd_valid_async", bus.rd_valid, 0);
    rst = 1'b0;
    bus.evt_i = '0;
    step();
    for (int a = 0; a < NUM_EVT + 3; a++) begin
      do_read(ADDR_W'(a), 8'h00, $sformatf("t6_reg%0d", a));
    end
    check_eq("t6_state_post", bus.state_o, 0);

    repeat (2) step();
    check_eq("rd_pending", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_monitor_multi.md
Name: perf_monitor_multi

Overview:
Parametrised performance monitoring unit for the pipelined core. It replaces the fixed cycle/instruction counter pair with one free-running cycle counter plus NUM_EVT generic event counters, fed by pulses such as stall, flush, retire and DM access. It adds a register-mapped config/read port, wrap or saturate modes, per-counter overflow flags, an overflow interrupt and freeze-on-overflow. It sits beside the pipeline top and samples its event strobes every clock.

Parameters:
NUM_EVT, 4, number of event counters (1..13)
CNT_W, 32, width of every counter (8..64)
ADDR_W, 4, config/read address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
evt_i  in  NUM_EVT  level event strobes; bit i high in a cycle = one count for counter i
cfg_we  in  1  config write strobe
cfg_addr  in  ADDR_W  config write address
cfg_wdata  in  CNT_W  config write data
rd_en  in  1  read request
rd_addr  in  ADDR_W  read address
rd_data  out  CNT_W  read data, registered
rd_valid  out  1  rd_data valid, one cycle after rd_en
ovf_irq  out  1  OR of all overflow status flags
state_o  out  2  FSM state (0 IDLE, 1 RUN, 2 FROZEN)

Behaviour:
- Clocking/reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all counters, CTRL, STATUS, rd_data, rd_valid and ovf_irq are 0. state_o = IDLE.
- Register map (word addresses):
  - 0 CTRL: bit0 en, bit1 freeze_on_ovf, bit2 sat.
  - 1 STATUS: bit0 is the cycle counter overflow; bit i+1 is event i overflow. Write-1-to-clear.
  - 2 CYCLE counter.
  - 3+i EVENT counter i.
  - Unmapped addresses read 0; writes to them are ignored.
  - Writes to a counter address load cfg_wdata.
- FSM transitions:
  - IDLE->RUN: CTRL write with en=1.
  - RUN->IDLE: CTRL write with en=0.
  - RUN->FROZEN: any counter overflows this cycle while freeze_on_ovf=1.
  - FROZEN->RUN: STATUS becomes all-zero with en=1.
  - FROZEN->IDLE: CTRL write with en=0.
  - state_o reflects the registered state.
- Counting: only in RUN. The CYCLE counter increments every RUN cycle. Event counter i increments in each RUN cycle where evt_i[i]=1. Counters hold in IDLE and FROZEN.
- Overflow, wrap mode (sat=0): all-ones +1 -> 0 and the flag is set.
- Overflow, sat mode (sat=1): the counter holds all-ones and the flag is set. The flag is set only on the attempted increment at all-ones.
- Freeze timing: the overflowing increment itself is applied in the RUN cycle. Counting stops from the next cycle.
- Simultaneous events:
  - A cfg write to a counter in the same cycle as its increment: the write wins and the increment is lost.
  - W1C and a new overflow on the same flag in the same cycle: set wins.
  - A CTRL write and an overflow in the same cycle: the CTRL write decides the next state.
- ovf_irq is registered and equals |STATUS of the previous cycle's update, i.e. it asserts the cycle after the flag sets.
- Read latency: rd_data and rd_valid update one cycle after rd_en.
  - A read of an address written in the same cycle returns the old value.
  - rd_valid deasserts when rd_en=0; rd_data holds its last value.
- Counter width: all counters are CNT_W bits. cfg_wdata is truncated/zero-extended per field; CTRL uses bits [2:0] and STATUS uses bits [NUM_EVT:0].
- Reset mid-operation: everything returns immediately to reset values, independent of clk.

Test Plan:
1. Reset, write CTRL=1, hold evt_i=4'b0101 for 10 cycles, write CTRL=0 -> CYCLE=10, EVT0=10, EVT1=0, EVT2=10, EVT3=0, state_o back to 0.
2. With CNT_W=8, load EVT1=8'hFE, CTRL=1 (wrap), evt_i[1]=1 for 3 cycles -> EVT1 sequence FF, 00, 01. STATUS bit2=1. ovf_irq=1 the cycle after the wrap.
3. Repeat scenario 2 with CTRL=3'b111 -> EVT1 holds FF, STATUS bit2=1, state_o=2 (FROZEN), CYCLE stops advancing. Write STATUS=4'b0100 -> state_o=1 and counting resumes.
4. Same cycle: cfg write EVT0=5 and evt_i[0]=1 in RUN -> EVT0 reads 5. Same cycle: W1C STATUS bit1 and EVT0 wraps -> bit1 stays 1.
5. rd_en at addr 2 in cycle t -> rd_valid=1 and rd_data = CYCLE value at t, both at t+1. Read of addr 15 -> 0.
6. Assert rst asynchronously between clock edges during RUN with nonzero counters -> all counters 0, state_o=0, ovf_irq=0 before the next edge.
